// File: rtl/host_cmd_parser.sv
// Host command parser: frames the 16-bit host word stream into command headers and a payload stream, checks the 32-bit payload sum.
// Define HOST_PARSER_TIMEOUT_EN to abort packets that stall mid-frame for timeout_cycles idle cycles.
module host_cmd_parser #(
  parameter int host_width     = 16,
  parameter int timeout_cycles = 65535
) (
  input  logic                  clk_host,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [host_width-1:0] in_data,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_dest,
  output logic [7:0]            cmd_code,
  output logic [23:0]           cmd_length,
  output logic                  pay_valid,
  input  logic                  pay_ready,
  output logic [host_width-1:0] pay_data,
  output logic                  cmd_done,
  output logic                  cmd_checksum_ok,
  output logic                  cmd_abort,
  output logic [7:0]            err_count,
  output logic [2:0]            dbg_state
);
  localparam logic [7:0] CMD_FIFO_WRITE   = 8'h01;
  localparam logic [7:0] AUD_FIFO_WRITE   = 8'h02;
  localparam logic [7:0] SELECT_CLOCK     = 8'h10;
  localparam logic [7:0] UPDATE_BLOCKING  = 8'h11;
  localparam logic [7:0] AUD_FIFO_READ    = 8'h12;

  typedef enum logic [2:0] {
    S_DEST, S_CMD, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM_HI, S_CSUM_LO
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            hdr_dest, hdr_code, len_hi;
  logic [host_width-1:0] csum_hi;
  logic [23:0]           pay_cnt, code_len, hdr_len;
  logic [31:0]           sum;
  logic                  framed, done_pend, accept, last_word, timeout_hit, err_inc, code_framed, csum_match;

  // Code decode; unlisted codes (including the reset/status group) are simple with no payload.
  always_comb begin
    code_framed = 1'b0;
    code_len    = '0;
    case (in_data[7:0])
      CMD_FIFO_WRITE, AUD_FIFO_WRITE: code_framed = 1'b1;
      SELECT_CLOCK, UPDATE_BLOCKING:  code_len = 24'd1;
      AUD_FIFO_READ:                  code_len = 24'd2;
      default:                        code_len = '0;
    endcase
  end

  assign hdr_len    = {len_hi, in_data[15:0]};
  assign last_word  = (pay_cnt == cmd_length - 24'd1);
  assign csum_match = ({csum_hi, in_data} == sum);
  assign err_inc    = timeout_hit || ((state == S_CSUM_LO) && in_valid && !csum_match);
  assign dbg_state  = state;

  always_ff @(posedge clk_host or negedge reset_n) begin
    if (!reset_n) state <= S_DEST;
    else          state <= state_nxt;
  end

  // Valid/ready: a word moves when in_valid & in_ready; in DATA the payload port passes straight through.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    pay_valid = 1'b0;
    pay_data  = '0;
    accept    = in_valid;
    case (state)
      S_DEST:   if (in_valid) state_nxt = S_CMD;
      S_CMD: begin
        if (in_valid) begin
          if (code_framed)          state_nxt = S_LEN_HI;
          else if (code_len == '0)  state_nxt = S_DEST;
          else                      state_nxt = S_DATA;
        end
      end
      S_LEN_HI: if (in_valid) state_nxt = S_LEN_LO;
      S_LEN_LO: if (in_valid) state_nxt = (hdr_len == '0) ? S_CSUM_HI : S_DATA;
      S_DATA: begin
        in_ready  = pay_ready;
        pay_valid = in_valid;
        pay_data  = in_data;
        accept    = in_valid && pay_ready;
        if (accept && last_word) state_nxt = framed ? S_CSUM_HI : S_DEST;
      end
      S_CSUM_HI: if (in_valid) state_nxt = S_CSUM_LO;
      S_CSUM_LO: if (in_valid) state_nxt = S_DEST;
      default:   state_nxt = S_DEST;
    endcase
    if (timeout_hit) state_nxt = S_DEST;
  end

  always_ff @(posedge clk_host or negedge reset_n) begin
    if (!reset_n) begin
      hdr_dest <= '0; hdr_code <= '0; len_hi <= '0; csum_hi <= '0;
      pay_cnt <= '0; sum <= '0; framed <= 1'b0; done_pend <= 1'b0;
      cmd_valid <= 1'b0; cmd_dest <= '0; cmd_code <= '0; cmd_length <= '0;
      cmd_done <= 1'b0; cmd_checksum_ok <= 1'b0; cmd_abort <= 1'b0; err_count <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_abort <= timeout_hit;
      done_pend <= 1'b0;
      // Zero-length simple commands finish one cycle after their cmd_valid.
      if (done_pend) begin
        cmd_done        <= 1'b1;
        cmd_checksum_ok <= 1'b1;
      end
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        S_DEST: begin
          sum     <= '0;
          pay_cnt <= '0;
          if (accept) hdr_dest <= in_data[7:0];
        end
        S_CMD: if (accept) begin
          hdr_code <= in_data[7:0];
          framed   <= code_framed;
          if (!code_framed) begin
            cmd_valid  <= 1'b1;
            cmd_dest   <= hdr_dest;
            cmd_code   <= in_data[7:0];
            cmd_length <= code_len;
            done_pend  <= (code_len == '0);
          end
        end
        S_LEN_HI: if (accept) len_hi <= in_data[7:0];
        S_LEN_LO: if (accept) begin
          cmd_valid  <= 1'b1;
          cmd_dest   <= hdr_dest;
          cmd_code   <= hdr_code;
          cmd_length <= hdr_len;
        end
        S_DATA: if (accept) begin
          sum     <= sum + 32'(in_data);
          pay_cnt <= pay_cnt + 24'd1;
          if (last_word && !framed) begin
            cmd_done        <= 1'b1;
            cmd_checksum_ok <= 1'b1;
          end
        end
        S_CSUM_HI: if (accept) csum_hi <= in_data;
        S_CSUM_LO: if (accept) begin
          cmd_done        <= 1'b1;
          cmd_checksum_ok <= csum_match;
        end
        default: ;
      endcase
    end
  end

`ifdef HOST_PARSER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Only cycles with no word offered count; a payload stall with in_valid high is not idle.
  assign timeout_hit = (state != S_DEST) && !in_valid && (idle_cnt == 16'(timeout_cycles - 1));

  always_ff @(posedge clk_host or negedge reset_n) begin
    if (!reset_n)                                   idle_cnt <= '0;
    else if (state == S_DEST || accept || timeout_hit) idle_cnt <= '0;
    else if (!in_valid)                             idle_cnt <= idle_cnt + 16'd1;
  end
`else
  // No idle counter in this build; the expression is constant false for any legal timeout_cycles.
  assign timeout_hit = (timeout_cycles < 0);
`endif
endmodule

// File: tb/tb_host_cmd_parser.sv
// Directed bench for host_cmd_parser: framed/simple packets, checksum errors, stalls, reset, saturation, optional timeout.
`timescale 1ns/1ps
module tb_host_cmd_parser;
  localparam logic [15:0] CMD_FIFO_WRITE  = 16'h0001;
  localparam logic [15:0] AUD_FIFO_WRITE  = 16'h0002;
  localparam logic [15:0] SELECT_CLOCK    = 16'h0010;
  localparam logic [15:0] AUD_FIFO_READ   = 16'h0012;
  localparam logic [15:0] RESET_SLOTS     = 16'h0020;
  localparam logic [15:0] ENTER_RESET     = 16'h0021;

  logic        clk_host = 1'b0, reset_n = 1'b0, in_valid = 1'b0, pay_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, cmd_valid, pay_valid, cmd_done, cmd_checksum_ok, cmd_abort;
  logic [7:0]  cmd_dest, cmd_code, err_count;
  logic [23:0] cmd_length;
  logic [15:0] pay_data;
  logic [2:0]  dbg_state;

  int vectors = 0, errors = 0;
  int n_valid = 0, n_done = 0, n_abort = 0, n_overlap = 0, base_valid, base_done;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] pkt_q[$];

  always #5 clk_host = ~clk_host;

  host_cmd_parser #(.host_width(16), .timeout_cycles(100)) dut (
    .clk_host(clk_host), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cmd_valid(cmd_valid), .cmd_dest(cmd_dest), .cmd_code(cmd_code),
    .cmd_length(cmd_length), .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .cmd_done(cmd_done), .cmd_checksum_ok(cmd_checksum_ok), .cmd_abort(cmd_abort),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  always @(negedge clk_host) begin
    if (reset_n) begin
      if (cmd_valid) n_valid++;
      if (cmd_done) n_done++;
      if (cmd_abort) n_abort++;
      if (cmd_valid && cmd_done) n_overlap++;
      if (pay_valid && pay_ready) got_q.push_back(pay_data);
    end
  end

  task automatic tick();
    @(posedge clk_host);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk_host);
      rdy = in_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 2000) begin
        check("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_pkt();
    while (pkt_q.size() > 0) send_word(pkt_q.pop_front());
  endtask

  task automatic check_payload(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_host);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_dest"}, 32'(cmd_dest), 32'd0);
    check({tag, "_cmd_length"}, 32'(cmd_length), 32'd0);
    check({tag, "_pay_valid"}, 32'(pay_valid), 32'd0);
    check({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
    check({tag, "_ok"}, 32'(cmd_checksum_ok), 32'd0);
    check({tag, "_abort"}, 32'(cmd_abort), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk_host);
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Framed packet, good checksum 0x47+0xA3=0xEA
    pkt_q = '{16'h0002, CMD_FIFO_WRITE, 16'h0000, 16'h0002, 16'h0047, 16'h00A3, 16'h0000, 16'h00EA};
    exp_q = '{16'h0047, 16'h00A3};
    send_pkt();
    repeat (3) tick();
    check("t1_valid_cnt", 32'(n_valid), 32'd1);
    check("t1_dest", 32'(cmd_dest), 32'h02);
    check("t1_code", 32'(cmd_code), 32'h01);
    check("t1_len", 32'(cmd_length), 32'd2);
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_ok", 32'(cmd_checksum_ok), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check_payload("t1_pay");

    // Same packet, wrong checksum
    pkt_q = '{16'h0002, CMD_FIFO_WRITE, 16'h0000, 16'h0002, 16'h0047, 16'h00A3, 16'h0000, 16'h00EB};
    exp_q = '{16'h0047, 16'h00A3};
    send_pkt();
    repeat (3) tick();
    check("t2_done_cnt", 32'(n_done), 32'd2);
    check("t2_ok", 32'(cmd_checksum_ok), 32'd0);
    check("t2_err", 32'(err_count), 32'd1);
    check_payload("t2_pay");

    // Simple SELECT_CLOCK immediately followed by a zero-length framed packet
    pkt_q = '{16'hAB00 | 16'h00FF, SELECT_CLOCK, 16'h0001};
    exp_q = '{16'h0001};
    send_pkt();
    check("t3_valid_cnt", 32'(n_valid), 32'd3);
    check("t3_dest", 32'(cmd_dest), 32'hFF);
    check("t3_len", 32'(cmd_length), 32'd1);
    pkt_q = '{16'h0001, CMD_FIFO_WRITE, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    send_pkt();
    repeat (3) tick();
    check("t5_valid_cnt", 32'(n_valid), 32'd4);
    check("t5_done_cnt", 32'(n_done), 32'd4);
    check("t5_dest", 32'(cmd_dest), 32'h01);
    check("t5_len", 32'(cmd_length), 32'd0);
    check("t5_ok", 32'(cmd_checksum_ok), 32'd1);
    check_payload("t35_pay");

    // 512-word framed packet (words 0,0,1,1..255,255; sum 0xFF00) with a 5-cycle pay_ready stall
    pkt_q = '{16'h0003, AUD_FIFO_WRITE, 16'h0000, 16'h0200};
    send_pkt();
    for (int k = 0; k < 512; k++) exp_q.push_back(16'(k >> 1));
    fork
      begin
        for (int k = 0; k < 512; k++) send_word(16'(k >> 1));
      end
      begin
        repeat (100) tick();
        pay_ready = 1'b0;
        repeat (5) begin
          @(negedge clk_host);
          check("t4_stall_in_ready", 32'(in_ready), 32'd0);
          tick();
        end
        pay_ready = 1'b1;
      end
    join
    pkt_q = '{16'h0000, 16'hFF00};
    send_pkt();
    repeat (3) tick();
    check("t4_dest", 32'(cmd_dest), 32'h03);
    check("t4_len", 32'(cmd_length), 32'h200);
    check("t4_done_cnt", 32'(n_done), 32'd5);
    check("t4_ok", 32'(cmd_checksum_ok), 32'd1);
    check_payload("t4_pay");

    // AUD_FIFO_READ (2 words), then back-to-back zero-length simple and unknown codes
    pkt_q = '{16'h0002, AUD_FIFO_READ, 16'h1234, 16'h5678};
    exp_q = '{16'h1234, 16'h5678};
    send_pkt();
    check("ar_len", 32'(cmd_length), 32'd2);
    check("ar_code", 32'(cmd_code), 32'h12);
    pkt_q = '{16'h0000, RESET_SLOTS, 16'h0001, ENTER_RESET, 16'h0003, 16'h007E};
    send_pkt();
    repeat (3) tick();
    check("zl_valid_cnt", 32'(n_valid), 32'd9);
    check("zl_done_cnt", 32'(n_done), 32'd9);
    check("zl_dest", 32'(cmd_dest), 32'h03);
    check("zl_code", 32'(cmd_code), 32'h7E);
    check("zl_len", 32'(cmd_length), 32'd0);
    check("zl_ok", 32'(cmd_checksum_ok), 32'd1);
    check("zl_overlap", 32'(n_overlap), 32'd0);
    check_payload("zl_pay");

`ifdef HOST_PARSER_TIMEOUT_EN
    // Stall after LEN_LO: abort after 100 idle cycles
    base_done = n_done;
    pkt_q = '{16'h0001, CMD_FIFO_WRITE, 16'h0000, 16'h0004};
    send_pkt();
    repeat (99) tick();
    check("to_no_abort_yet", 32'(n_abort), 32'd0);
    repeat (2) tick();
    check("to_abort_cnt", 32'(n_abort), 32'd1);
    check("to_err", 32'(err_count), 32'd2);
    check("to_no_done", 32'(n_done), 32'(base_done));
    check("to_state", 32'(dbg_state), 32'd0);
    pkt_q = '{16'h0002, CMD_FIFO_WRITE, 16'h0000, 16'h0003, 16'h0011, 16'h0022};
    send_pkt();
`else
    // Without the idle counter the parser waits in DATA indefinitely
    pkt_q = '{16'h0001, CMD_FIFO_WRITE, 16'h0000, 16'h0004};
    send_pkt();
    repeat (120) tick();
    check("nto_state", 32'(dbg_state), 32'd4);
    check("nto_abort_cnt", 32'(n_abort), 32'd0);
`endif
    check("mid_data_state", 32'(dbg_state), 32'd4);

    // Reset mid-DATA discards the packet
    reset_n = 1'b0;
    check_reset_outputs("rst_mid");
    tick();
    reset_n = 1'b1;
    got_q.delete();
    tick();

    base_valid = n_valid;
    base_done  = n_done;
    pkt_q = '{16'h0002, CMD_FIFO_WRITE, 16'h0000, 16'h0002, 16'h0047, 16'h00A3, 16'h0000, 16'h00EA};
    exp_q = '{16'h0047, 16'h00A3};
    send_pkt();
    repeat (3) tick();
    check("rec_valid", 32'(n_valid - base_valid), 32'd1);
    check("rec_done", 32'(n_done - base_done), 32'd1);
    check("rec_ok", 32'(cmd_checksum_ok), 32'd1);
    check("rec_err", 32'(err_count), 32'd0);
    check_payload("rec_pay");

    // err_count saturation with bad zero-length framed packets
    for (int i = 0; i < 260; i++) begin
      pkt_q = '{16'h0000, CMD_FIFO_WRITE, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
      send_pkt();
      if (i == 253) begin
        repeat (2) tick();
        check("sat_fe", 32'(err_count), 32'hFE);
      end
      if (i == 254) begin
        repeat (2) tick();
        check("sat_ff", 32'(err_count), 32'hFF);
      end
    end
    repeat (3) tick();
    check("sat_hold", 32'(err_count), 32'hFF);
    check("sat_ok", 32'(cmd_checksum_ok), 32'd0);
    check_payload("sat_pay");
    check("final_overlap", 32'(n_overlap), 32'd0);
`ifdef HOST_PARSER_TIMEOUT_EN
    check("final_abort", 32'(n_abort), 32'd1);
`else
    check("final_abort", 32'(n_abort), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
